// File: rtl/pwm_dac_pkg.sv
// Shared types and default widths for the PWM / R2R DAC transmit path.
package pwm_dac_pkg;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_PRESCALE   = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } dac_state_t;
endpackage

// File: rtl/pwm_dac_transmitter_fifo.sv
// Synchronous sample FIFO; full/empty derive only from the registered level.
module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/pwm_dac_transmitter.sv
// PWM + R2R DAC transmitter: one buffered code per PWM period, swapped only at period boundaries.
module pwm_dac_transmitter
  import pwm_dac_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic [DATA_W-1:0]             r2r_out,
  output logic [DATA_W-1:0]             active_code,
  output logic                          period_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output dac_state_t                    dbg_state
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Stream handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
  // sample_ready is !full of the registered level, so a same-cycle pop never raises it.
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  dac_state_t        state_q;
  dac_state_t        state_d;
  logic [PW-1:0]     presc;
  logic [DATA_W-1:0] counter;
  logic              running;
  logic              tick;
  logic              boundary;
  logic              start_d;
  logic              under_d;

  assign sample_ready = !fifo_full;
  assign push         = sample_valid && sample_ready;
  assign running      = (state_q == RUN) || (state_q == STOP);
  assign tick         = running && (presc == PW'(PRESCALE - 1));
  assign boundary     = tick && (counter == '1);
  assign dbg_state    = state_q;

  sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sample_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A boundary with enable low ends the run without popping; STOP with enable high resumes RUN.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start_d = 1'b0;
    under_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN, STOP: begin
        if (boundary) begin
          if (enable) begin
            state_d = RUN;
            start_d = 1'b1;
            if (!fifo_empty) pop = 1'b1;
            else             under_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = enable ? RUN : STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc        <= '0;
      counter      <= '0;
      pwm_out      <= 1'b0;
      active_code  <= '0;
      r2r_out      <= '0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      period_start <= start_d;
      underrun     <= under_d;
      pwm_out      <= running && (counter < active_code);
      if (pop) begin
        active_code <= fifo_dout;
        r2r_out     <= fifo_dout;
      end
      if (!running) begin
        presc   <= '0;
        counter <= '0;
      end else if (tick) begin
        presc   <= '0;
        counter <= counter + 1'b1;
      end else begin
        presc   <= presc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_dac_transmitter.sv
// Scoreboard bench for pwm_dac_transmitter: per-period code/underrun/duty model against the DUT.
module tb_pwm_dac_transmitter;
  import pwm_dac_pkg::*;

  localparam int DATA_W   = 8;
  localparam int PRESCALE = 3;
  localparam int DEPTH    = 4;
  localparam int PERIOD   = PRESCALE * (1 << DATA_W);
  localparam int LIMIT    = PERIOD + 50;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              pwm_out;
  logic [DATA_W-1:0] r2r_out;
  logic [DATA_W-1:0] active_code;
  logic              period_start;
  logic              underrun;
  logic [2:0]        fifo_level;
  dac_state_t        dbg_state;

  pwm_dac_transmitter #(
    .DATA_W     (DATA_W),
    .PRESCALE   (PRESCALE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .r2r_out      (r2r_out),
    .active_code  (active_code),
    .period_start (period_start),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_t[$];
  logic [DATA_W-1:0] last_code = '0;
  bit                mon_en = 1'b0;
  bit                have_win = 1'b0;
  bit                have_prev = 1'b0;
  bit                gap_ok = 1'b0;
  int                win_high = 0;
  int                win_code = 0;
  int                last_ps = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Record every accepted sample with the edge it transferred on.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst && sample_valid && sample_ready) begin
      exp_q.push_back(sample_data);
      exp_t.push_back(cyc);
    end
  end

  // Monitor: each period start consumes the oldest sample accepted before that edge, else underruns.
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_code;
    logic              exp_under;
    if (mon_en) begin
      if (period_start) begin
        if (have_win) check("pwm_high_count", win_high, win_code * PRESCALE);
        if (have_prev && gap_ok) check("period_len", cyc - last_ps, PERIOD);
        if (exp_q.size() > 0 && exp_t[0] < cyc) begin
          exp_code  = exp_q.pop_front();
          void'(exp_t.pop_front());
          exp_under = 1'b0;
        end else begin
          exp_code  = last_code;
          exp_under = 1'b1;
        end
        check("underrun", underrun, exp_under);
        last_code = exp_code;
        win_code  = exp_code;
        win_high  = 0;
        have_win  = 1'b1;
        have_prev = 1'b1;
        last_ps   = cyc;
        gap_ok    = 1'b1;
      end else begin
        check("underrun_idle", underrun, 0);
      end
      check("active_code", active_code, last_code);
      check("r2r_out", r2r_out, last_code);
      check("fifo_level", fifo_level, exp_q.size());
      check("sample_ready", sample_ready, exp_q.size() < DEPTH);
      if (have_win && pwm_out) win_high++;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic push(input logic [DATA_W-1:0] code);
    int n = 0;
    sample_valid = 1'b1;
    sample_data  = code;
    while (!sample_ready && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) check("push_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < LIMIT);
    if (!period_start) check("period_start_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pwm"}, pwm_out, 0);
    check({tag, "_ps"}, period_start, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_active"}, active_code, 0);
    check({tag, "_r2r"}, r2r_out, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_ready"}, sample_ready, 1);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    @(negedge clk);
    check_reset_values("reset_init");
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single code, never refilled: held with underrun at every later boundary.
    push(8'h40);
    sample_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) wait_ps();

    // Back-to-back extremes then mid-scale.
    push(8'h00);
    push(8'hFF);
    push(8'h80);
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) wait_ps();

    // Random codes with random gaps while running.
    for (int i = 0; i < 10; i++) begin
      idle_cycles($urandom_range(0, 500));
      push(8'($urandom_range(0, 255)));
      sample_valid = 1'b0;
    end
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) wait_ps();
    wait_ps();

    // Reset in the middle of a period.
    idle_cycles(200);
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_run");
    exp_q.delete();
    exp_t.delete();
    last_code = '0;
    have_win  = 1'b0;
    have_prev = 1'b0;
    enable = 1'b0;
    rst = 1'b1;
    mon_en = 1'b1;
    idle_cycles(3);

    // Fill the FIFO in IDLE; the fifth sample stalls until the first pop.
    fork
      begin
        for (int i = 0; i < 5; i++) push(8'($urandom_range(1, 254)));
        sample_valid = 1'b0;
      end
    join_none
    idle_cycles(10);
    check("ready_low_when_full", sample_ready, 0);
    check("level_full_in_idle", fifo_level, DEPTH);
    check("state_idle_while_filling", dbg_state, IDLE);
    enable = 1'b1;
    wait fork;
    for (int i = 0; i < 6; i++) wait_ps();

    // Drop enable mid-period: the period completes, then IDLE without popping.
    push(8'hFF);
    sample_valid = 1'b0;
    wait_ps();
    p = cyc;
    push(8'h33);
    sample_valid = 1'b0;
    idle_cycles(100 - (cyc - p));
    gap_ok = 1'b0;
    enable = 1'b0;
    idle_cycles(p + PERIOD - 1 - cyc);
    check("stop_before_boundary", dbg_state, STOP);
    @(negedge clk);
    check("idle_at_boundary", dbg_state, IDLE);
    check("pwm_low_in_idle", pwm_out, 0);
    idle_cycles(20);
    check("last_period_high", win_high, 255 * PRESCALE);
    check("level_kept_after_stop", fifo_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: actual=timeout expected=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
